imm_encode: RTL and testbench
=============================

// Module: imm_encode
// PURPOSE
//  Inverse of the immediate sign-extender: packs a signed 32-bit immediate into the
//  RISC-V instruction bit positions selected by ImmSrc and merges it into a base word.
//  Range and alignment are checked, with an error sideband.
//  Two-stage valid/ready pipeline, one word per cycle.
//  Sits between the program loader / self-test generator and instruction memory.
// PARAMETERS
//  CNT_W        16  width of the saturating error counter
//  CHECK_RANGE  1   1: range/alignment check drives Err; 0: Err tied 0, count stays 0
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      asynchronous reset, active-low
//  in_valid   in   1      input word valid
//  in_ready   out  1      input accepted when in_valid && in_ready
//  Imm        in   32     signed immediate, byte offset for B/J
//  ImmSrc     in   2      00 I, 01 S, 10 B, 11 J (same code as the sign-extender)
//  Base       in   32     instruction holding opcode/rd/rs/funct; immediate bits ignored
//  out_valid  out  1      Instr/Err valid
//  out_ready  in   1      consumer accepts when out_valid && out_ready
//  Instr      out  32     encoded instruction
//  Err        out  1      immediate out of range or misaligned for ImmSrc
//  err_count  out  CNT_W  count of accepted words with Err=1, saturating
// BEHAVIOUR
//  Reset (rst_n low, async): both stages empty; out_valid=0, Instr=0, Err=0, err_count=0.
//   in_ready=0 while rst_n low; in_ready=1 from the first edge after release.
//  Field packing. Bits not listed come from Base:
//   I: Instr[31:20]=Imm[11:0]
//   S: [31:25]=Imm[11:5], [11:7]=Imm[4:0]
//   B: [31]=Imm[12], [30:25]=Imm[10:5], [11:8]=Imm[4:1], [7]=Imm[11]
//   J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12]
//  Err rules:
//   I/S: Imm[31:11] not all equal
//   B: Imm[31:12] not all equal, or Imm[0]=1
//   J: Imm[31:20] not all equal, or Imm[0]=1
//  On Err the truncated fields are still emitted; nothing is dropped.
//  Stage 1 captures Imm, ImmSrc, Base and the computed Err on input accept.
//  Stage 2 registers the merged Instr and Err. Latency is 2 cycles from accept to out_valid.
//  Advance: s2 loads when s2 is empty or out_ready=1. s1 loads when s1 is empty or s1 advances.
//   in_ready = !s1_full || s1_advance. Full throughput at 1/cycle, no bubbles.
//  Stall: while out_valid && !out_ready, Instr and Err hold stable and no word is lost or duplicated.
//  err_count increments on out_valid && out_ready && Err, and holds at 2^CNT_W-1.
//  Simultaneous accept-in and accept-out in a full pipe: both happen in the same cycle.
//  Reset mid-operation discards in-flight words; err_count clears.
//  Round-trip property: when Err=0, the sign-extender applied to (Instr, ImmSrc) returns Imm.
// STRUCTURE
//  Shared package: IMM_I/IMM_S/IMM_B/IMM_J ImmSrc constants, used by the extender too.
//  Sub-module imm_field_pack: combinational pack + range check, (Imm, ImmSrc, Base) -> (Instr, Err).
//  Stage registers, handshake and counter stay in imm_encode.
// TESTING
//  Reference model: the bench instantiates the sign-extender on Instr/ImmSrc and checks the
//  round trip on every Err=0 word.
//  1. I: Imm=-1 (FFFFFFFF), Base=00000013 -> Instr=FFF00013, Err=0. Imm=2048 -> Err=1.
//  2. S: Imm=-32, Base=00002023 -> Instr=FE002023, Err=0. Imm=-2049 -> Err=1.
//  3. B: Imm=-4096, Base=00000063 -> Instr=80000063, Err=0. Imm=6 -> Err=0; Imm=3 -> Err=1.
//  4. J: Imm=0x000FFFFE -> Err=0 and round trip holds. Imm=0x00100000 -> Err=1.
//  5. Backpressure: stream 8 words, out_ready low for 3 cycles mid-stream.
//   -> in_ready drops once both stages are full; output is held stable;
//      all 8 words come out in order, exactly once.
//  6. Drive 5 error words, then assert rst_n=0 mid-stream
//   -> err_count=5 before reset; out_valid=0 and err_count=0 immediately on reset.

Source files
------------

// File: rtl/imm_encode_pkg.sv
// Shared immediate-format codes and helpers for the immediate encoder and sign-extender.
package imm_encode_pkg;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // True when every bit of v from position lsb upward equals the sign bit,
  // i.e. v survives truncation to lsb+1 bits as a signed value.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
    logic signed [31:0] w_shifted;
    w_shifted = $signed(v) >>> lsb;
    return (w_shifted == 32'sd0) || (w_shifted == -32'sd1);
  endfunction

endpackage

// File: rtl/imm_encode_field_pack.sv
// Combinational immediate scatter into instruction fields plus range/alignment check.
module imm_field_pack
  import imm_encode_pkg::*;
#(
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic [31:0] i_imm,
  input  logic [1:0]  i_src,
  input  logic [31:0] i_base,
  output logic [31:0] o_instr,
  output logic        o_err
);

  logic w_range_ok;
  logic w_aligned;

  always_comb begin
    o_instr    = i_base;
    w_range_ok = 1'b1;
    w_aligned  = 1'b1;
    case (i_src)
      IMM_I: begin
        o_instr[31:20] = i_imm[11:0];
        w_range_ok     = fits_signed(i_imm, 11);
      end
      IMM_S: begin
        o_instr[31:25] = i_imm[11:5];
        o_instr[11:7]  = i_imm[4:0];
        w_range_ok     = fits_signed(i_imm, 11);
      end
      IMM_B: begin
        o_instr[31]    = i_imm[12];
        o_instr[30:25] = i_imm[10:5];
        o_instr[11:8]  = i_imm[4:1];
        o_instr[7]     = i_imm[11];
        w_range_ok     = fits_signed(i_imm, 12);
        w_aligned      = ~i_imm[0];
      end
      default: begin
        o_instr[31]    = i_imm[20];
        o_instr[30:21] = i_imm[10:1];
        o_instr[20]    = i_imm[11];
        o_instr[19:12] = i_imm[19:12];
        w_range_ok     = fits_signed(i_imm, 20);
        w_aligned      = ~i_imm[0];
      end
    endcase
    // Out-of-range words are still packed (truncated); only the flag reports it.
    o_err = CHECK_RANGE ? ~(w_range_ok & w_aligned) : 1'b0;
  end

endmodule

// File: rtl/imm_extend.sv
// RISC-V immediate sign-extender: recovers the signed immediate from an instruction word.
module imm_extend
  import imm_encode_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [1:0]  i_src,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = 32'd0;
    case (i_src)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: o_imm = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default: o_imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/imm_encode.sv
// Two-stage valid/ready immediate encoder: stage 1 holds the raw word, stage 2 the
// packed instruction and error flag; saturating count of delivered error words.
module imm_encode
  import imm_encode_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      Imm,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             Err,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_rdy_en;
  logic             r_s1_full;
  logic [31:0]      r_s1_imm;
  logic [1:0]       r_s1_src;
  logic [31:0]      r_s1_base;
  logic             r_s2_full;
  logic [31:0]      r_instr;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [31:0] w_pack_instr;
  logic        w_pack_err;
  logic        w_s2_load;
  logic        w_s1_adv;
  logic        w_s1_load;
  logic        w_in_acc;
  logic        w_out_acc;

  imm_field_pack #(.CHECK_RANGE(CHECK_RANGE)) u_pack (
    .i_imm   (r_s1_imm),
    .i_src   (r_s1_src),
    .i_base  (r_s1_base),
    .o_instr (w_pack_instr),
    .o_err   (w_pack_err)
  );

  assign w_s2_load = ~r_s2_full | out_ready;
  assign w_s1_adv  = r_s1_full & w_s2_load;
  assign w_s1_load = ~r_s1_full | w_s1_adv;
  // r_rdy_en keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = r_rdy_en & w_s1_load;
  assign w_in_acc  = in_valid & in_ready;
  assign w_out_acc = r_s2_full & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en  <= 1'b0;
      r_s1_full <= 1'b0;
      r_s1_imm  <= 32'd0;
      r_s1_src  <= 2'd0;
      r_s1_base <= 32'd0;
      r_s2_full <= 1'b0;
      r_instr   <= 32'd0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_s2_load) begin
        r_s2_full <= r_s1_full;
        if (r_s1_full) begin
          r_instr <= w_pack_instr;
          r_err   <= w_pack_err;
        end
      end
      if (w_s1_load) begin
        r_s1_full <= w_in_acc;
        if (w_in_acc) begin
          r_s1_imm  <= Imm;
          r_s1_src  <= ImmSrc;
          r_s1_base <= Base;
        end
      end
      if (w_out_acc && r_err && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_s2_full;
  assign Instr     = r_instr;
  assign Err       = r_err;
  assign err_count = r_cnt;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: directed table, randomized stream against an arithmetic model,
// backpressure and mid-stream reset sequences, round trip through the sign-extender.
module tb_imm_encode;
  import imm_encode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Imm;
  logic [1:0]  ImmSrc;
  logic [31:0] Base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        Err;
  logic [15:0] err_count;

  logic [1:0]  chk_src;
  logic [31:0] ext_imm;

  always #5 clk = ~clk;

  imm_encode #(.CNT_W(16), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Imm(Imm), .ImmSrc(ImmSrc), .Base(Base), .out_valid(out_valid),
    .out_ready(out_ready), .Instr(Instr), .Err(Err), .err_count(err_count)
  );

  imm_extend u_ext (.i_instr(Instr), .i_src(chk_src), .o_imm(ext_imm));

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t        sb[$];
  vec_t        cur_vec;
  vec_t        tab[9];
  int          n_checks = 0;
  int          n_fail = 0;
  int          model_cnt = 0;
  int          n_out = 0;
  bit          last_acc;
  bit          last_in_ready;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_instr;
  logic        stall_err;

  // Which immediate bit lands in instruction bit pos (-1: bit comes from Base).
  function automatic int src_bit(input logic [1:0] src, input int pos);
    case (src)
      IMM_I: return (pos >= 20) ? pos - 20 : -1;
      IMM_S: begin
        if (pos >= 25) return pos - 20;
        if (pos >= 7 && pos <= 11) return pos - 7;
        return -1;
      end
      IMM_B: begin
        if (pos == 31) return 12;
        if (pos >= 25) return pos - 20;
        if (pos >= 8 && pos <= 11) return pos - 7;
        if (pos == 7) return 11;
        return -1;
      end
      default: begin
        if (pos == 31) return 20;
        if (pos >= 21) return pos - 20;
        if (pos == 20) return 11;
        if (pos >= 12) return pos;
        return -1;
      end
    endcase
  endfunction

  function automatic vec_t model(input logic [31:0] imm, input logic [1:0] src,
                                 input logic [31:0] base);
    vec_t   v;
    longint s;
    longint lim;
    bit     need_even;
    int     k;
    s = longint'($signed(imm));
    case (src)
      IMM_I, IMM_S: lim = 2048;
      IMM_B:        lim = 4096;
      default:      lim = longint'(1) << 20;
    endcase
    need_even = (src == IMM_B) || (src == IMM_J);
    v.err   = (s < -lim) || (s >= lim) || (need_even && (s % 2 != 0));
    v.instr = base;
    for (int pos = 0; pos < 32; pos++) begin
      k = src_bit(src, pos);
      if (k >= 0) v.instr[pos] = imm[k];
    end
    v.imm  = imm;
    v.src  = src;
    v.base = base;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe outputs on the falling edge, return just after the rising edge.
  task automatic step();
    vec_t e;
    @(negedge clk);
    if (stall_prev) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_instr", Instr, stall_instr);
      check("stall_err", 32'(Err), 32'(stall_err));
    end
    stall_prev    = out_valid && !out_ready;
    stall_instr   = Instr;
    stall_err     = Err;
    last_in_ready = in_ready;
    last_acc      = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h with nothing outstanding", Instr);
      end else begin
        e = sb.pop_front();
        check("instr", Instr, e.instr);
        check("err", 32'(Err), 32'(e.err));
        if (e.err && model_cnt < 65535) model_cnt++;
        if (!e.err) begin
          chk_src = e.src;
          #1;
          check("round_trip", ext_imm, e.imm);
        end
      end
    end
    if (last_acc) sb.push_back(cur_vec);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    cur_vec  = v;
    Imm      = v.imm;
    ImmSrc   = v.src;
    Base     = v.base;
    in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v);
    int t;
    drive(v);
    for (t = 0; t < 50; t++) begin
      step();
      if (last_acc) break;
    end
    if (t == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && sb.size() > 0; t++) step();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic apply_reset();
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    model_cnt  = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_err", 32'(Err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] edges[12];
    edges = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4096,
              32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000, 32'hFFF00000,
              32'hFFEFFFFE};
    case ($urandom % 4)
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       return edges[$urandom % 12];
      default: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endfunction

  initial begin
    int   pend;
    int   sent;
    int   out0;
    bit   saw_low;
    vec_t rv;
    vec_t bp[8];

    in_valid  = 1'b0;
    out_ready = 1'b1;
    Imm       = '0;
    ImmSrc    = '0;
    Base      = '0;
    chk_src   = '0;

    tab[0] = '{32'hFFFFFFFF, IMM_I, 32'h00000013, 32'hFFF00013, 1'b0};
    tab[1] = '{32'd2048,     IMM_I, 32'h00000013, 32'h80000013, 1'b1};
    tab[2] = '{32'hFFFFFFE0, IMM_S, 32'h00002023, 32'hFE002023, 1'b0};
    tab[3] = '{32'hFFFFF7FF, IMM_S, 32'h00002023, 32'h7E002FA3, 1'b1};
    tab[4] = '{32'hFFFFF000, IMM_B, 32'h00000063, 32'h80000063, 1'b0};
    tab[5] = '{32'd6,        IMM_B, 32'h00000063, 32'h00000363, 1'b0};
    tab[6] = '{32'd3,        IMM_B, 32'h00000063, 32'h00000163, 1'b1};
    tab[7] = '{32'h000FFFFE, IMM_J, 32'h0000006F, 32'h7FFFF06F, 1'b0};
    tab[8] = '{32'h00100000, IMM_J, 32'h0000006F, 32'h8000006F, 1'b1};

    apply_reset();

    // Directed table, streamed back to back.
    for (int i = 0; i < 9; i++) send(tab[i]);
    drain();
    check("table_err_count", 32'(err_count), 32'd4);

    // Randomized traffic with random valid gaps and backpressure.
    pend = 0;
    sent = 0;
    rv   = model(rand_imm(), 2'($urandom % 4), $urandom);
    for (int c = 0; c < 3000 && sent < 300; c++) begin
      if (!pend) begin
        rv   = model(rand_imm(), 2'($urandom % 4), $urandom);
        pend = 1;
      end
      drive(rv);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      step();
      if (last_acc) begin
        pend = 0;
        sent++;
      end
    end
    check("random_sent", 32'(sent), 32'd300);
    drain();
    check("random_err_count", 32'(err_count), 32'(model_cnt));

    // Backpressure: 8 words, consumer stalls for 3 cycles mid-stream.
    for (int i = 0; i < 8; i++) bp[i] = model(32'(i * 2 + 100), IMM_B, 32'h00000063 + 32'(i << 12));
    out0    = n_out;
    sent    = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (sent < 8) drive(bp[sent]);
      else in_valid = 1'b0;
      step();
      if (c >= 3 && c <= 5 && in_valid && !last_in_ready) saw_low = 1'b1;
      if (last_acc) sent++;
      if (sent == 8 && sb.size() == 0) break;
    end
    check("bp_in_ready_dropped", 32'(saw_low), 32'd1);
    check("bp_out_count", 32'(n_out - out0), 32'd8);
    drain();

    // Five error words, then reset while more are in flight.
    apply_reset();
    for (int i = 0; i < 5; i++) send(model(32'd4096 + 32'(i), IMM_I, 32'h00000013));
    drain();
    check("err5_count", 32'(err_count), 32'd5);
    send(model(32'd5000, IMM_S, 32'h00002023));
    drive(model(32'd7, IMM_J, 32'h0000006F));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    apply_reset();
    check("post_midrst_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
